mdu_sequencer: RTL and testbench

Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO registers and the shared 32-cycle shift/add–subtract datapath. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and raises a stall request to the hazard logic whenever a dependent instruction reaches it while the unit is busy. It sits beside the ALU in E and feeds HI/LO to the E-stage result mux.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_iter_dp.sv | 47 ++++
 rtl/mdu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared types and constants for the multiply/divide sequencer slice.
//   mdu_op_t    : encoding of op_e (MULT, MULTU, DIV, DIVU)
//   mdu_state_t : sequencer FSM states (IDLE, RUN, FIX)
//   MDU_ITER    : default iteration count, equal to the operand width
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_dp.sv
// mdu_iter_dp
// One combinational iteration of the shared multiply/divide datapath.
// Multiply: shift-add, consuming one multiplier bit (LSB first) per step.
//   The {acc_hi,acc_lo} pair is the partial product, shifted right.
// Divide: restoring divide, producing one quotient bit (MSB first) per step.
//   acc_hi is the partial remainder and acc_lo collects quotient bits.
// Ports:
//   is_div          in  select divide (1) or multiply (0) step
//   acc_hi, acc_lo  in  current accumulator halves
//   opnd            in  multiplicand (mul) or divisor (div), magnitude form
//   xbit            in  current multiplier bit (mul) or dividend bit (div)
//   nxt_hi, nxt_lo  out accumulator halves after this step
module mdu_iter_dp #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] acc_hi,
  input  logic [W-1:0] acc_lo,
  input  logic [W-1:0] opnd,
  input  logic         xbit,
  output logic [W-1:0] nxt_hi,
  output logic [W-1:0] nxt_lo
);

  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] sub;
  logic         ge;

  // Both step flavours are computed every cycle and the op picks one.
  // The divide trial subtraction only needs the low W bits of the
  // difference: when the shifted remainder is >= divisor, the true
  // difference is below the divisor and therefore fits in W bits.
  always_comb begin
    sum     = {1'b0, acc_hi} + (xbit ? {1'b0, opnd} : '0);
    shifted = {acc_hi, xbit};
    ge      = (shifted >= {1'b0, opnd});
    sub     = shifted[W-1:0] - opnd;
    nxt_hi  = sum[W:1];
    nxt_lo  = {sum[0], acc_lo[W-1:1]};
    if (is_div) begin
      nxt_hi = ge ? sub : shifted[W-1:0];
      nxt_lo = {acc_lo[W-2:0], ge};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Iterative multiply/divide unit for the E stage. Owns HI/LO and drives the
// shared one-bit-per-cycle datapath for MULT/MULTU/DIV/DIVU. Signed ops run
// on magnitudes and the sign is restored in the FIX state.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start_e, op_e       mul/div instruction valid in E and its opcode
//   srca_e, srcb_e      forwarded rs / rt operands
//   mthi_e, mtlo_e      move-to-HI/LO in E (honoured only in IDLE)
//   mfhilo_d            MFHI/MFLO in D
//   hi, lo              architectural HI/LO
//   busy                unit not idle
//   stall_req           combinational stall request to the hazard unit
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_e,
  input  logic [1:0]      op_e,
  input  logic [ITER-1:0] srca_e,
  input  logic [ITER-1:0] srcb_e,
  input  logic            mthi_e,
  input  logic            mtlo_e,
  input  logic            mfhilo_d,
  output logic [ITER-1:0] hi,
  output logic [ITER-1:0] lo,
  output logic            busy,
  output logic            stall_req
);

  localparam int CW = $clog2(ITER);

  mdu_state_t      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [ITER-1:0] acc_hi, acc_lo;
  logic [ITER-1:0] opnd, xreg;
  logic [ITER-1:0] hi_q, lo_q;
  mdu_op_t         op_q;
  logic            neg_q, sa_q, dz_q;

  logic            is_div_e, is_signed_e, sa_e, sb_e, div_zero_e;
  logic [ITER-1:0] abs_a, abs_b;
  logic [ITER-1:0] dp_hi, dp_lo;
  logic [ITER-1:0] fix_hi, fix_lo;
  logic            xbit;

  // Decode the incoming E-stage instruction: signedness, operand signs,
  // magnitudes and the divide-by-zero shortcut.
  always_comb begin
    is_div_e    = op_e[1];
    is_signed_e = ~op_e[0];
    sa_e        = is_signed_e & srca_e[ITER-1];
    sb_e        = is_signed_e & srcb_e[ITER-1];
    abs_a       = sa_e ? ('0 - srca_e) : srca_e;
    abs_b       = sb_e ? ('0 - srcb_e) : srcb_e;
    div_zero_e  = is_div_e && (srcb_e == '0);
  end

  // Multiply consumes the multiplier from the bottom, divide consumes the
  // dividend from the top, so the feed bit comes from opposite ends of xreg.
  assign xbit = op_q[1] ? xreg[ITER-1] : xreg[0];

  mdu_iter_dp #(.W(ITER)) u_dp (
    .is_div (op_q[1]),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .xbit   (xbit),
    .nxt_hi (dp_hi),
    .nxt_lo (dp_lo)
  );

  // Sign restoration applied while in FIX. Signed multiply negates the whole
  // 64-bit product; signed divide negates the quotient when signs differ
  // and gives the remainder the dividend's sign. A divide by zero keeps the
  // raw {dividend, all-ones} pair untouched.
  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (!dz_q) begin
      if (op_q == MULT && neg_q) begin
        {fix_hi, fix_lo} = '0 - {acc_hi, acc_lo};
      end else if (op_q == DIV) begin
        if (neg_q) fix_lo = '0 - acc_lo;
        if (sa_q)  fix_hi = '0 - acc_hi;
      end
    end
  end

  // FSM state register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A start seen while busy is ignored here; the pipeline
  // keeps it in E via stall_req and it is picked up once back in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_e) state_nxt = div_zero_e ? FIX : RUN;
      RUN:  if (cnt == CW'(ITER - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and architectural registers. IDLE latches operands (or the
  // divide-by-zero result directly) and services MTHI/MTLO when no start is
  // present. RUN steps the datapath once per cycle. FIX commits HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      xreg   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= MULT;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_e) begin
            op_q  <= mdu_op_t'(op_e);
            neg_q <= sa_e ^ sb_e;
            sa_q  <= sa_e;
            cnt   <= '0;
            opnd  <= is_div_e ? abs_b : abs_a;
            xreg  <= is_div_e ? abs_a : abs_b;
            if (div_zero_e) begin
              dz_q   <= 1'b1;
              acc_hi <= srca_e;
              acc_lo <= '1;
            end else begin
              dz_q   <= 1'b0;
              acc_hi <= '0;
              acc_lo <= '0;
            end
          end else begin
            if (mthi_e) hi_q <= srca_e;
            if (mtlo_e) lo_q <= srca_e;
          end
        end
        RUN: begin
          acc_hi <= dp_hi;
          acc_lo <= dp_lo;
          cnt    <= cnt + CW'(1);
          xreg   <= op_q[1] ? {xreg[ITER-2:0], 1'b0} : {1'b0, xreg[ITER-1:1]};
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state != IDLE);
  assign stall_req = busy & (start_e | mthi_e | mtlo_e | mfhilo_d);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
// Directed self-checking bench for mdu_sequencer. Each task drives one
// scenario and compares outputs against hand-computed values. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_e;
  logic [1:0]  op_e;
  logic [31:0] srca_e, srcb_e;
  logic        mthi_e, mtlo_e, mfhilo_d;
  logic [31:0] hi, lo;
  logic        busy, stall_req;

  int checks = 0;
  int passed = 0;

  mdu_sequencer #(.ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_e   (start_e),
    .op_e      (op_e),
    .srca_e    (srca_e),
    .srcb_e    (srcb_e),
    .mthi_e    (mthi_e),
    .mtlo_e    (mtlo_e),
    .mfhilo_d  (mfhilo_d),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one op, then count cycles with busy high (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int ncyc);
    @(negedge clk);
    op_e = op; srca_e = a; srcb_e = b; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_e = 1'b1; op_e = 2'b01;
    srca_e = 32'h5; srcb_e = 32'h6;
    mthi_e = 1'b0; mtlo_e = 1'b0; mfhilo_d = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passed++;
    checks++;
    if (hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 00000000", hi);
    else passed++;
    checks++;
    if (lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 00000000", lo);
    else passed++;
    checks++;
    if (stall_req !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall_req);
    else passed++;
    start_e = 1'b0; mfhilo_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu_max();
    int n;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checks++;
    if (hi !== 32'hFFFF_FFFE) $display("[TB] FAIL multu_max_hi: got %h expected fffffffe", hi);
    else passed++;
    checks++;
    if (lo !== 32'h0000_0001) $display("[TB] FAIL multu_max_lo: got %h expected 00000001", lo);
    else passed++;
    checks++;
    if (n != 33) $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", n);
    else passed++;
  endtask

  task automatic test_mult_signed();
    int n;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, n);
    checks++;
    if (hi !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_neg_hi: got %h expected ffffffff", hi);
    else passed++;
    checks++;
    if (lo !== 32'hFFFF_FFF1) $display("[TB] FAIL mult_neg_lo: got %h expected fffffff1", lo);
    else passed++;
  endtask

  task automatic test_div_signed();
    int n;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, n);
    checks++;
    if (lo !== 32'hFFFF_FFFD) $display("[TB] FAIL div_neg_quo: got %h expected fffffffd", lo);
    else passed++;
    checks++;
    if (hi !== 32'hFFFF_FFFF) $display("[TB] FAIL div_neg_rem: got %h expected ffffffff", hi);
    else passed++;
  endtask

  task automatic test_divu_zero();
    int n;
    run_op(2'b11, 32'h0000_000A, 32'h0000_0000, n);
    checks++;
    if (hi !== 32'h0000_000A) $display("[TB] FAIL divz_hi: got %h expected 0000000a", hi);
    else passed++;
    checks++;
    if (lo !== 32'hFFFF_FFFF) $display("[TB] FAIL divz_lo: got %h expected ffffffff", lo);
    else passed++;
    checks++;
    if (n != 1) $display("[TB] FAIL divz_busy_cycles: got %0d expected 1", n);
    else passed++;
  endtask

  task automatic test_div_overflow();
    int n;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++;
    if (lo !== 32'h8000_0000) $display("[TB] FAIL div_ovf_quo: got %h expected 80000000", lo);
    else passed++;
    checks++;
    if (hi !== 32'h0000_0000) $display("[TB] FAIL div_ovf_rem: got %h expected 00000000", hi);
    else passed++;
  endtask

  task automatic test_stall();
    int n, bad;
    @(negedge clk);
    op_e = 2'b01; srca_e = 32'd6; srcb_e = 32'd7; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) $display("[TB] FAIL stall_no_request: got %b expected 0", stall_req);
    else passed++;
    mfhilo_d = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b1) $display("[TB] FAIL stall_comb_rise: got %b expected 1", stall_req);
    else passed++;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (stall_req !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL stall_held: got %0d low cycles expected 0", bad);
    else passed++;
    checks++;
    if (stall_req !== 1'b0) $display("[TB] FAIL stall_release: got %b expected 0", stall_req);
    else passed++;
    checks++;
    if (lo !== 32'd42) $display("[TB] FAIL stall_result_lo: got %0d expected 42", lo);
    else passed++;
    mfhilo_d = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    op_e = 2'b01; srca_e = 32'd6; srcb_e = 32'd7; start_e = 1'b1;
    @(negedge clk);
    srca_e = 32'd3; srcb_e = 32'd4;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 33) $display("[TB] FAIL b2b_first_cycles: got %0d expected 33", n);
    else passed++;
    checks++;
    if (lo !== 32'd42) $display("[TB] FAIL b2b_first_lo: got %0d expected 42", lo);
    else passed++;
    checks++;
    if (stall_req !== 1'b0) $display("[TB] FAIL b2b_idle_stall: got %b expected 0", stall_req);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL b2b_second_accept: got %b expected 1", busy);
    else passed++;
    start_e = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 33) $display("[TB] FAIL b2b_second_cycles: got %0d expected 33", n);
    else passed++;
    checks++;
    if (lo !== 32'd12) $display("[TB] FAIL b2b_second_lo: got %0d expected 12", lo);
    else passed++;
    checks++;
    if (hi !== 32'd0) $display("[TB] FAIL b2b_second_hi: got %h expected 00000000", hi);
    else passed++;
  endtask

  task automatic test_move();
    @(negedge clk);
    srca_e = 32'hDEAD_BEEF; mthi_e = 1'b1;
    @(negedge clk);
    mthi_e = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF) $display("[TB] FAIL mthi_hi: got %h expected deadbeef", hi);
    else passed++;
    checks++;
    if (lo !== 32'd12) $display("[TB] FAIL mthi_lo_kept: got %h expected 0000000c", lo);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_e = 2'b01; srca_e = 32'd6; srcb_e = 32'd7; start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy);
    else passed++;
    checks++;
    if (hi !== 32'h0) $display("[TB] FAIL midreset_hi: got %h expected 00000000", hi);
    else passed++;
    checks++;
    if (lo !== 32'h0) $display("[TB] FAIL midreset_lo: got %h expected 00000000", lo);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL midreset_abandon: got %b expected 0", busy);
    else passed++;
    srca_e = 32'h0000_1234; mtlo_e = 1'b1;
    @(negedge clk);
    mtlo_e = 1'b0;
    checks++;
    if (lo !== 32'h0000_1234) $display("[TB] FAIL mtlo_lo: got %h expected 00001234", lo);
    else passed++;
    checks++;
    if (hi !== 32'h0) $display("[TB] FAIL mtlo_hi_kept: got %h expected 00000000", hi);
    else passed++;
  endtask

  initial begin
    $display("[TB] mdu_sequencer directed bench start");
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_divu_zero();
    test_div_overflow();
    test_stall();
    test_back_to_back();
    test_move();
    test_reset_mid();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
